muldiv_hilo: RTL and testbench

- Multi-cycle multiply/divide unit in the EX stage that owns the architectural HI/LO registers.
- Operands come from the EX-stage forwarding muxes (forwarded rs/rt values).
- RHLOut drives the "00" (HI/LO read) input of the EX result-select mux for MFHI/MFLO.
- Busy goes to the hazard unit, which stalls any HI/LO reader or new mul/div op while an operation is in flight.

---
 rtl/muldiv_hilo.sv | 231 +++++++++++++++++++++++
 tb/tb_muldiv_hilo.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_hilo.sv
// muldiv_hilo: multi-cycle multiply/divide unit that owns the architectural HI/LO registers.
// MUL_CYCLES sets the number of cycles from a multiply issue until HI/LO hold the result.
// Optional build macro MULDIV_MADD_EN adds MADD/MADDU/MSUB/MSUBU, which accumulate into {HI,LO}.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no op in flight; MDOp is accepted here when Flush=0
// MUL    | multiply in flight; cnt counts down to the HI/LO write cycle
// DIV    | one restoring-division step per cycle, 32 steps
// FIX    | sign fixup of quotient/remainder, then HI/LO write
module muldiv_hilo #(
  parameter int MUL_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  MDOp,
  input  logic        Flush,
  input  logic        RHLSel,
  output logic [31:0] RHLOut,
  output logic        Busy
);

  localparam logic [3:0] OP_MULT  = 4'b0001;
  localparam logic [3:0] OP_MULTU = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0011;
  localparam logic [3:0] OP_DIVU  = 4'b0100;
  localparam logic [3:0] OP_MTHI  = 4'b0101;
  localparam logic [3:0] OP_MTLO  = 4'b0110;
`ifdef MULDIV_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'b0111;
  localparam logic [3:0] OP_MADDU = 4'b1000;
  localparam logic [3:0] OP_MSUB  = 4'b1001;
  localparam logic [3:0] OP_MSUBU = 4'b1010;
`endif

  // The write happens at the end of cycle MUL_CYCLES-1, so the count starts at MUL_CYCLES-2.
  localparam logic [4:0] MUL_LOAD = 5'(MUL_CYCLES - 2);
  localparam logic [4:0] DIV_LOAD = 5'd31;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  // opa holds the multiplicand, or the dividend magnitude that shifts into the quotient.
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [32:0] rem_q, rem_d;
  logic        sgn_q, sgn_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic        busy_q, busy_d;
`ifdef MULDIV_MADD_EN
  logic        acc_add_q, acc_add_d;
  logic        acc_sub_q, acc_sub_d;
`endif

  logic [63:0] mul_prod;
  logic [63:0] mul_result;
  logic [33:0] div_shift;
  logic [33:0] div_diff;
  logic        div_signed;
  logic [31:0] a_mag;
  logic [31:0] b_mag;

  // Product from the latched operands; sign-extending to 64 bits gives the signed product.
  always_comb begin
    if (sgn_q)
      mul_prod = {{32{opa_q[31]}}, opa_q} * {{32{opb_q[31]}}, opb_q};
    else
      mul_prod = {32'b0, opa_q} * {32'b0, opb_q};
  end

  // Final multiply value; accumulate uses HI/LO as they stand at the write.
  always_comb begin
`ifdef MULDIV_MADD_EN
    if (acc_add_q)
      mul_result = {hi_q, lo_q} + mul_prod;
    else if (acc_sub_q)
      mul_result = {hi_q, lo_q} - mul_prod;
    else
      mul_result = mul_prod;
`else
    mul_result = mul_prod;
`endif
  end

  // Operand magnitudes for division; a zero divisor falls out naturally as
  // quotient all-ones and remainder |A|, which the fixup turns into the defined result.
  assign div_signed = (MDOp == OP_DIV);
  assign a_mag      = (div_signed && A[31]) ? (~A + 32'd1) : A;
  assign b_mag      = (div_signed && B[31]) ? (~B + 32'd1) : B;
  assign div_shift  = {rem_q, opa_q[31]};
  assign div_diff   = div_shift - {2'b00, opb_q};

  // Next-state, datapath and Busy.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    rem_d   = rem_q;
    sgn_d   = sgn_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`ifdef MULDIV_MADD_EN
    acc_add_d = acc_add_q;
    acc_sub_d = acc_sub_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!Flush) begin
          case (MDOp)
            OP_MULT, OP_MULTU: begin
              state_d = S_MUL;
              cnt_d   = MUL_LOAD;
              opa_d   = A;
              opb_d   = B;
              sgn_d   = (MDOp == OP_MULT);
`ifdef MULDIV_MADD_EN
              acc_add_d = 1'b0;
              acc_sub_d = 1'b0;
`endif
            end
`ifdef MULDIV_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
              state_d   = S_MUL;
              cnt_d     = MUL_LOAD;
              opa_d     = A;
              opb_d     = B;
              sgn_d     = (MDOp == OP_MADD) || (MDOp == OP_MSUB);
              acc_add_d = (MDOp == OP_MADD) || (MDOp == OP_MADDU);
              acc_sub_d = (MDOp == OP_MSUB) || (MDOp == OP_MSUBU);
            end
`endif
            OP_DIV, OP_DIVU: begin
              state_d = S_DIV;
              cnt_d   = DIV_LOAD;
              opa_d   = a_mag;
              opb_d   = b_mag;
              rem_d   = 33'd0;
              sgn_d   = div_signed;
              qneg_d  = div_signed && (A[31] ^ B[31]);
              rneg_d  = div_signed && A[31];
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      S_MUL: begin
        if (Flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == 5'd0) begin
          {hi_d, lo_d} = mul_result;
          state_d      = S_IDLE;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      S_DIV: begin
        if (Flush) begin
          state_d = S_IDLE;
        end else begin
          rem_d = div_diff[33] ? div_shift[32:0] : div_diff[32:0];
          opa_d = {opa_q[30:0], ~div_diff[33]};
          if (cnt_q == 5'd0)
            state_d = S_FIX;
          else
            cnt_d = cnt_q - 5'd1;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!Flush) begin
          lo_d = qneg_q ? (~opa_q + 32'd1) : opa_q;
          hi_d = rneg_q ? (~rem_q[31:0] + 32'd1) : rem_q[31:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers, all cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      opa_q   <= 32'd0;
      opb_q   <= 32'd0;
      rem_q   <= 33'd0;
      sgn_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef MULDIV_MADD_EN
      acc_add_q <= 1'b0;
      acc_sub_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      rem_q   <= rem_d;
      sgn_q   <= sgn_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      busy_q  <= busy_d;
`ifdef MULDIV_MADD_EN
      acc_add_q <= acc_add_d;
      acc_sub_q <= acc_sub_d;
`endif
    end
  end

  assign RHLOut = RHLSel ? hi_q : lo_q;
  assign Busy   = busy_q;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Directed plus randomized bench for muldiv_hilo against an arithmetic HI/LO model.
module tb_muldiv_hilo;
  localparam int MC = 3;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [3:0]  MDOp = '0;
  logic        Flush = 1'b0;
  logic        RHLSel = 1'b0;
  logic [31:0] RHLOut;
  logic        Busy;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic        bad_issue = 1'b0;

  muldiv_hilo #(.MUL_CYCLES(MC)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .MDOp(MDOp), .Flush(Flush),
    .RHLSel(RHLSel), .RHLOut(RHLOut), .Busy(Busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rst_n && Busy && MDOp != OP_NONE) bad_issue <= 1'b1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic read_hl(input logic sel, output logic [31:0] v);
    RHLSel = sel;
    #1;
    v = RHLOut;
  endtask

  function automatic int exp_busy(input logic [3:0] op);
    case (op)
      OP_MULT, OP_MULTU: return MC - 1;
      OP_DIV, OP_DIVU:   return 33;
`ifdef MULDIV_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: return MC - 1;
`endif
      default: return 0;
    endcase
  endfunction

  // Architectural result of one completed op, from plain 64-bit arithmetic.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] acc;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    acc = {m_hi, m_lo};
    case (op)
      OP_MULT:  {m_hi, m_lo} = 64'(sa * sb);
      OP_MULTU: {m_hi, m_lo} = 64'(ua * ub);
      OP_DIV: begin
        if (b == 32'd0) begin
          m_lo = a[31] ? 32'h0000_0001 : 32'hFFFF_FFFF;
          m_hi = a;
        end else begin
          m_lo = 32'(sa / sb);
          m_hi = 32'(sa % sb);
        end
      end
      OP_DIVU: begin
        if (b == 32'd0) begin
          m_lo = 32'hFFFF_FFFF;
          m_hi = a;
        end else begin
          m_lo = 32'(ua / ub);
          m_hi = 32'(ua % ub);
        end
      end
      OP_MTHI: m_hi = a;
      OP_MTLO: m_lo = a;
`ifdef MULDIV_MADD_EN
      OP_MADD:  {m_hi, m_lo} = acc + 64'(sa * sb);
      OP_MADDU: {m_hi, m_lo} = acc + 64'(ua * ub);
      OP_MSUB:  {m_hi, m_lo} = acc - 64'(sa * sb);
      OP_MSUBU: {m_hi, m_lo} = acc - 64'(ua * ub);
`endif
      default: ;
    endcase
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (Busy !== 1'b0 && k < 100) begin
      k++;
      step();
    end
    if (k >= 100) chk({tag, " idle timeout"}, {31'b0, Busy}, 32'd0);
  endtask

  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input string tag);
    int n, eb;
    logic [31:0] old_lo, v;
    wait_idle(tag);
    old_lo = m_lo;
    eb = exp_busy(op);
    MDOp = op; A = a; B = b;
    step();
    MDOp = OP_NONE; A = $urandom; B = $urandom;
    model(op, a, b);
    if (eb > 0) begin
      read_hl(1'b0, v);
      chk({tag, " old LO while busy"}, v, old_lo);
    end
    n = 0;
    while (Busy === 1'b1 && n < 100) begin
      n++;
      step();
    end
    chk({tag, " busy cycles"}, 32'(n), 32'(eb));
    read_hl(1'b1, v);
    chk({tag, " HI"}, v, m_hi);
    read_hl(1'b0, v);
    chk({tag, " LO"}, v, m_lo);
  endtask

  logic [3:0] op_list [$];

  initial begin
    logic [31:0] v, ra, rb;
    int r;

    #2;
    chk("reset Busy", {31'b0, Busy}, 32'd0);
    read_hl(1'b0, v); chk("reset LO", v, 32'd0);
    read_hl(1'b1, v); chk("reset HI", v, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    do_op(OP_MULT,  32'hFFFF_FFFE, 32'h0000_0003, "mult");
    do_op(OP_MULTU, 32'hFFFF_FFFE, 32'h0000_0003, "multu");
    do_op(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, "div -7/2");
    do_op(OP_DIVU,  32'd10,        32'd0,         "divu by zero");
    do_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, "div overflow");
    do_op(OP_DIV,   32'hFFFF_FFF0, 32'd0,         "div neg by zero");
    do_op(OP_DIV,   32'd100,       32'hFFFF_FFF9, "div 100/-7");
    do_op(OP_MTLO,  32'h1234_5678, 32'd0,         "mtlo");
    do_op(4'd11,    32'hDEAD_BEEF, 32'd5,         "unused 1011");
    do_op(4'd15,    32'hDEAD_BEEF, 32'd5,         "unused 1111");

    // DIV accepted, then flushed in its cycle 10.
    MDOp = OP_DIV; A = 32'd1000; B = 32'd7;
    step();
    MDOp = OP_NONE;
    for (int i = 0; i < 9; i++) step();
    Flush = 1'b1;
    step();
    Flush = 1'b0;
    chk("flush mid-div Busy", {31'b0, Busy}, 32'd0);
    read_hl(1'b0, v); chk("flush mid-div LO", v, 32'h1234_5678);
    read_hl(1'b1, v); chk("flush mid-div HI", v, m_hi);

    // Flush in the issue cycle blocks acceptance.
    MDOp = OP_DIV; A = 32'd77; B = 32'd3; Flush = 1'b1;
    step();
    MDOp = OP_NONE; Flush = 1'b0;
    chk("flush at issue Busy", {31'b0, Busy}, 32'd0);
    step(); step();
    read_hl(1'b0, v); chk("flush at issue LO", v, m_lo);

    // Flush in the final multiply cycle suppresses the write.
    MDOp = OP_MULT; A = 32'd6; B = 32'd7;
    step();
    MDOp = OP_NONE;
    for (int i = 0; i < MC - 2; i++) step();
    Flush = 1'b1;
    step();
    Flush = 1'b0;
    chk("flush final write Busy", {31'b0, Busy}, 32'd0);
    read_hl(1'b0, v); chk("flush final write LO", v, m_lo);
    read_hl(1'b1, v); chk("flush final write HI", v, m_hi);

    // Reset in cycle 20 of a divide.
    MDOp = OP_DIV; A = 32'hFFFF_0000; B = 32'd3;
    step();
    MDOp = OP_NONE;
    for (int i = 0; i < 19; i++) step();
    rst_n = 1'b0;
    #1;
    m_hi = '0; m_lo = '0;
    chk("reset mid-div Busy", {31'b0, Busy}, 32'd0);
    read_hl(1'b0, v); chk("reset mid-div LO", v, 32'd0);
    read_hl(1'b1, v); chk("reset mid-div HI", v, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    do_op(OP_MULT, 32'd12345, 32'hFFFF_FF00, "mult after reset");

`ifdef MULDIV_MADD_EN
    do_op(OP_MTHI,  32'd0,         32'd0, "mthi 0");
    do_op(OP_MTLO,  32'hFFFF_FFFF, 32'd0, "mtlo ones");
    do_op(OP_MADDU, 32'd1,         32'd1, "maddu carry");
    do_op(OP_MTHI,  32'd0,         32'd0, "mthi 0b");
    do_op(OP_MTLO,  32'd0,         32'd0, "mtlo 0");
    do_op(OP_MSUB,  32'd1,         32'd1, "msub from zero");
`else
    do_op(OP_MADD,  32'd3, 32'd4, "madd disabled");
    do_op(OP_MSUBU, 32'd3, 32'd4, "msubu disabled");
`endif

    op_list = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO};
`ifdef MULDIV_MADD_EN
    op_list.push_back(OP_MADD);
    op_list.push_back(OP_MADDU);
    op_list.push_back(OP_MSUB);
    op_list.push_back(OP_MSUBU);
`endif
    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      rb = $urandom;
      r = $urandom_range(0, 7);
      if (r == 0) rb = 32'd0;
      if (r == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      if (r == 2) rb = rb >> $urandom_range(0, 31);
      do_op(op_list[$urandom_range(0, op_list.size() - 1)], ra, rb, "random");
    end

    chk("no op issued while busy", {31'b0, bad_issue}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
